oam_dma: RTL and testbench
==========================

OAM_DMA -- requirements
Module: oam_dma

Interface
REQ-001 SHALL have parameter TRIG_ADDR, default 16'h4014, the CPU write address that starts a transfer.
REQ-002 SHALL have parameter OAM_ADDR, default 16'h2004, the destination port written for every byte.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port CLK, input, 1 bit: system clock, also the CPU clock.
REQ-005 SHALL have port RST_N, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port CPU_ADDR, input, 16 bits: CPU bus address.
REQ-007 SHALL have port CPU_DOUT, input, 8 bits: CPU write data.
REQ-008 SHALL have port CPU_WREQ, input, 1 bit: CPU write strobe.
REQ-009 SHALL have port CPU_CE, output, 1 bit: CPU ready; 0 stalls the CPU.
REQ-010 SHALL have port BUS_ADDR, output, 16 bits: shared memory bus address.
REQ-011 SHALL have port BUS_DOUT, output, 8 bits: shared bus write data.
REQ-012 SHALL have port BUS_WREQ, output, 1 bit: shared bus write strobe.
REQ-013 SHALL have port BUS_DIN, input, 8 bits: shared bus read data, forwarded to the CPU externally.
REQ-014 SHALL have port BUSY, output, 1 bit: a transfer is in progress.

Function
REQ-015 SHALL have five states: IDLE, HALT, ALIGN, READ, WRITE.
REQ-016 In IDLE, BUS_ADDR, BUS_DOUT and BUS_WREQ SHALL pass CPU_ADDR, CPU_DOUT and CPU_WREQ through combinationally, with CPU_CE=1 and BUSY=0.
REQ-017 In IDLE, when CPU_WREQ=1 and CPU_ADDR==TRIG_ADDR, the block SHALL latch PAGE<=CPU_DOUT, clear the byte counter CNT[7:0] to 0 and go to HALT at the next edge.
REQ-018 The triggering write itself SHALL reach the bus unchanged.
REQ-019 In every state other than IDLE, the block SHALL hold CPU_CE=0 and BUSY=1, and CPU signals SHALL NOT reach the bus.
REQ-020 HALT SHALL last 1 cycle, then go to ALIGN if PAR=1, otherwise to READ.
REQ-021 PAR is a free-running 1-bit cycle-parity flop, toggled every CLK.
REQ-022 ALIGN SHALL last 1 cycle with no bus access (BUS_WREQ=0), then go to READ.
REQ-023 In READ, BUS_ADDR SHALL be {PAGE,CNT} and BUS_WREQ=0; BUS_DIN SHALL be captured into TR at the end of the cycle; the next state SHALL be WRITE.
REQ-024 In WRITE, BUS_ADDR SHALL be OAM_ADDR, BUS_DOUT=TR and BUS_WREQ=1; CNT SHALL increment by 1 (8-bit).
REQ-025 From WRITE, if CNT==8'hFF the next state SHALL be IDLE, else READ.
REQ-026 A transfer SHALL move exactly 256 bytes, from {PAGE,00} through {PAGE,FF}; CNT wraps to 0 on completion.
REQ-027 Total stall SHALL be 513 cycles (PAR=0 at HALT) or 514 cycles (PAR=1).
REQ-028 CPU_CE SHALL return to 1 in the first IDLE cycle.
REQ-029 Trigger writes while BUSY=1 SHALL be ignored.
REQ-030 PAGE=8'hFF SHALL read FF00..FFFF with no carry into other pages.

Reset
REQ-031 Asserting RST_N=0 SHALL asynchronously force state=IDLE, CNT=0, PAGE=0, TR=0, PAR=0.
REQ-032 During reset the outputs SHALL be CPU_CE=1 and BUSY=0, with the bus in pass-through.
REQ-033 Reset mid-transfer SHALL abort the transfer with no further DMA writes; bytes already written remain written.

Configuration
REQ-034 Macro OAM_DMA_ALIGN_EN defined: ALIGN is used per REQ-020.
REQ-035 Macro OAM_DMA_ALIGN_EN undefined: HALT SHALL always go to READ, the ALIGN state and PAR logic are absent, and the stall is always 513 cycles.

Structure
REQ-036 A shared package SHALL hold the state encoding, the TRIG_ADDR/OAM_ADDR defaults and the stall-length constants (513/514).
REQ-037 One sub-module SHALL exist: oam_dma_mux, a combinational bus-owner select (CPU vs DMA) driving BUS_ADDR, BUS_DOUT and BUS_WREQ.

Verification
REQ-038 CPU write 8'h02 to 4014 at PAR=0: CPU_CE low for 513 cycles; bus reads 0200..02FF; 256 writes to 2004 with data matching a preloaded RAM pattern.
REQ-039 Same trigger at PAR=1: CPU_CE low for 514 cycles; one ALIGN cycle with BUS_WREQ=0 before the first read of 0200.
REQ-040 Trigger with page 8'hFF: last read address is FFFF; the next state after the final write is IDLE; CNT==0.
REQ-041 RST_N pulsed low after the 100th write: CPU_CE=1 immediately; no write to 2004 afterwards; the next trigger restarts at {PAGE,00}.
REQ-042 Second trigger write (to 4014) injected while BUSY=1: PAGE unchanged and the transfer length is unchanged.
REQ-043 Idle traffic (write 8'h55 to 0300, read 2002): bus mirrors CPU signals with zero latency and CPU_CE=1.

Source files
------------

// File: rtl/oam_dma_pkg.sv
// ---------------------------------------------------------------------------
// oam_dma_pkg
// Shared definitions for the sprite-memory DMA engine: FSM state encoding,
// the default trigger and destination addresses, the stall-length constants,
// and the bus request record used by the bus-owner multiplexer.
// Optional feature macro: OAM_DMA_ALIGN_EN (enables the ALIGN state).
// ---------------------------------------------------------------------------
package oam_dma_pkg;

    // Default CPU write address that starts a transfer.
    localparam logic [15:0] TRIG_ADDR_DEF = 16'h4014;
    // Default destination port written for every byte.
    localparam logic [15:0] OAM_ADDR_DEF  = 16'h2004;

    // CPU stall length: one HALT cycle plus 256 read/write pairs, plus one
    // ALIGN cycle when the transfer starts on an odd CPU cycle.
    localparam int STALL_EVEN = 513;
    localparam int STALL_ODD  = 514;

    // FSM state encoding.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_HALT  = 3'd1;
    localparam logic [2:0] ST_ALIGN = 3'd2;
    localparam logic [2:0] ST_READ  = 3'd3;
    localparam logic [2:0] ST_WRITE = 3'd4;

    // One bus request: address, write data and write strobe.
    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  dout;
        logic        wreq;
    } bus_req_t;

    // Expected stall length for a transfer, given whether ALIGN is taken.
    function automatic int stall_cycles(input logic align);
        return align ? STALL_ODD : STALL_EVEN;
    endfunction

endpackage

// File: rtl/oam_dma_mux.sv
// ---------------------------------------------------------------------------
// oam_dma_mux
// Combinational bus-owner select. The CPU owns the shared bus while the DMA
// engine is idle; the DMA engine owns it for the whole transfer.
// Ports:
//   dma_own  - 1: DMA engine drives the bus, 0: CPU drives the bus
//   cpu_req  - CPU address / write data / write strobe
//   dma_req  - DMA address / write data / write strobe
//   bus_req  - selected request driven onto the shared bus
// ---------------------------------------------------------------------------
module oam_dma_mux
    import oam_dma_pkg::*;
(
    input  logic     dma_own,
    input  bus_req_t cpu_req,
    input  bus_req_t dma_req,
    output bus_req_t bus_req
);

    assign bus_req = dma_own ? dma_req : cpu_req;

endmodule

// File: rtl/oam_dma.sv
// ---------------------------------------------------------------------------
// oam_dma
// Sprite-memory DMA engine. A CPU write of a page number to TRIG_ADDR stalls
// the CPU and copies the 256 bytes {PAGE,00}..{PAGE,FF} to the OAM_ADDR port,
// one read cycle followed by one write cycle per byte.
// Optional feature: define OAM_DMA_ALIGN_EN to insert one ALIGN cycle when the
// transfer starts on an odd cycle (stall 514 instead of 513). Without it the
// ALIGN state and the parity flop are absent and the stall is always 513.
// Ports:
//   CLK, RST_N           - clock, asynchronous active-low reset
//   CPU_ADDR/DOUT/WREQ   - CPU bus request
//   CPU_CE               - CPU ready (0 stalls the CPU)
//   BUS_ADDR/DOUT/WREQ   - shared memory bus request
//   BUS_DIN              - shared bus read data
//   BUSY                 - transfer in progress
// ---------------------------------------------------------------------------
module oam_dma
    import oam_dma_pkg::*;
#(
    parameter logic [15:0] TRIG_ADDR = TRIG_ADDR_DEF,
    parameter logic [15:0] OAM_ADDR  = OAM_ADDR_DEF
)
(
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] CPU_ADDR,
    input  logic [7:0]  CPU_DOUT,
    input  logic        CPU_WREQ,
    output logic        CPU_CE,
    output logic [15:0] BUS_ADDR,
    output logic [7:0]  BUS_DOUT,
    output logic        BUS_WREQ,
    input  logic [7:0]  BUS_DIN,
    output logic        BUSY
);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [7:0] page;
    logic [7:0] cnt;
    logic [7:0] tr;
    logic       trigger;
    logic       dma_own;
    bus_req_t   cpu_req;
    bus_req_t   dma_req;
    bus_req_t   bus_req;

`ifdef OAM_DMA_ALIGN_EN
    // Free-running cycle parity; decides whether HALT is followed by ALIGN.
    logic par;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) par <= 1'b0;
        else        par <= ~par;
    end
`endif

    // Trigger writes are only honoured while idle; during a transfer the CPU
    // is stalled and its bus signals never reach the bus.
    assign trigger = (state == ST_IDLE) && CPU_WREQ && (CPU_ADDR == TRIG_ADDR);

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            ST_IDLE:  if (trigger) state_nxt = ST_HALT;
`ifdef OAM_DMA_ALIGN_EN
            ST_HALT:  state_nxt = par ? ST_ALIGN : ST_READ;
`else
            ST_HALT:  state_nxt = ST_READ;
`endif
            ST_ALIGN: state_nxt = ST_READ;
            ST_READ:  state_nxt = ST_WRITE;
            ST_WRITE: state_nxt = (cnt == 8'hFF) ? ST_IDLE : ST_READ;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
            page  <= 8'h00;
            cnt   <= 8'h00;
            tr    <= 8'h00;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge values.
            state <= state_nxt;
            if (trigger) begin
                page <= CPU_DOUT;
                cnt  <= 8'h00;
            end
            if (state == ST_READ)  tr  <= BUS_DIN;
            // Wraps FF -> 00 on the final write, leaving the counter cleared.
            if (state == ST_WRITE) cnt <= cnt + 8'd1;
        end
    end

    assign dma_own = (state != ST_IDLE);
    assign CPU_CE  = ~dma_own;
    assign BUSY    = dma_own;

    assign cpu_req = '{addr: CPU_ADDR, dout: CPU_DOUT, wreq: CPU_WREQ};

    // Reads address {PAGE,CNT}; only WRITE strobes the bus, so HALT and
    // ALIGN present a harmless read address with no write.
    assign dma_req = '{addr: (state == ST_WRITE) ? OAM_ADDR : {page, cnt},
                       dout: tr,
                       wreq: (state == ST_WRITE)};

    oam_dma_mux u_mux (
        .dma_own (dma_own),
        .cpu_req (cpu_req),
        .dma_req (dma_req),
        .bus_req (bus_req)
    );

    assign BUS_ADDR = bus_req.addr;
    assign BUS_DOUT = bus_req.dout;
    assign BUS_WREQ = bus_req.wreq;

endmodule

// File: tb/tb_oam_dma.sv
// ---------------------------------------------------------------------------
// tb_oam_dma
// Self-checking bench for oam_dma. A behavioural model tracks "cycles since
// the trigger" and derives from it what the bus must show each cycle; a
// compare process checks every cycle on the falling edge. Directed scenarios
// add literal checks on stall length, read range and write count.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_oam_dma;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic [15:0] CPU_ADDR = 16'h1234;
    logic [7:0]  CPU_DOUT = 8'hA5;
    logic        CPU_WREQ = 1'b0;
    logic        CPU_CE;
    logic [15:0] BUS_ADDR;
    logic [7:0]  BUS_DOUT;
    logic        BUS_WREQ;
    logic [7:0]  BUS_DIN;
    logic        BUSY;

`ifdef OAM_DMA_ALIGN_EN
    localparam bit ALIGN_ON = 1'b1;
`else
    localparam bit ALIGN_ON = 1'b0;
`endif

    logic [7:0] ram [0:65535];
    assign BUS_DIN = ram[BUS_ADDR];

    always #5 CLK = ~CLK;

    oam_dma dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .CPU_ADDR (CPU_ADDR),
        .CPU_DOUT (CPU_DOUT),
        .CPU_WREQ (CPU_WREQ),
        .CPU_CE   (CPU_CE),
        .BUS_ADDR (BUS_ADDR),
        .BUS_DOUT (BUS_DOUT),
        .BUS_WREQ (BUS_WREQ),
        .BUS_DIN  (BUS_DIN),
        .BUSY     (BUSY)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_t counts cycles since the transfer began (0 = halt cycle). A transfer
    // occupies 1 + align + 2*256 cycles.
    int         m_cycles = 0;
    bit         m_busy   = 1'b0;
    int         m_t      = 0;
    logic [7:0] m_page   = 8'h00;
    bit         m_align  = 1'b0;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_cycles = 0;
            m_busy   = 1'b0;
            m_t      = 0;
            m_page   = 8'h00;
            m_align  = 1'b0;
        end else begin
            m_cycles++;
            if (m_busy) begin
                m_t++;
                if (m_t == 1 + int'(m_align) + 512) m_busy = 1'b0;
            end else if (CPU_WREQ && CPU_ADDR == 16'h4014) begin
                m_busy  = 1'b1;
                m_t     = 0;
                m_page  = CPU_DOUT;
                m_align = ALIGN_ON && (m_cycles % 2 == 1);
            end
        end
    end

    // ---------------- per-cycle compare + statistics ----------------
    int          dma_writes = 0;
    int          ce_run     = 0;
    int          last_stall = 0;
    logic [15:0] first_read = 16'h0000;
    logic [15:0] last_read  = 16'h0000;

    always @(negedge CLK) begin
        int         p;
        logic [7:0] idx;
        if (!m_busy) begin
            check("idle_cpu_ce",   CPU_CE,   1);
            check("idle_busy",     BUSY,     0);
            check("idle_bus_addr", BUS_ADDR, CPU_ADDR);
            check("idle_bus_dout", BUS_DOUT, CPU_DOUT);
            check("idle_bus_wreq", BUS_WREQ, CPU_WREQ);
        end else begin
            check("xfer_cpu_ce", CPU_CE, 0);
            check("xfer_busy",   BUSY,   1);
            p   = m_t - 1 - int'(m_align);
            idx = 8'(p / 2);
            if (p < 0) begin
                check("halt_align_wreq", BUS_WREQ, 0);
            end else if (p % 2 == 0) begin
                check("read_addr", BUS_ADDR, {m_page, idx});
                check("read_wreq", BUS_WREQ, 0);
                if (p == 0) first_read = BUS_ADDR;
                last_read = BUS_ADDR;
            end else begin
                check("write_addr", BUS_ADDR, 16'h2004);
                check("write_data", BUS_DOUT, ram[{m_page, idx}]);
                check("write_wreq", BUS_WREQ, 1);
            end
        end
        if (BUSY && BUS_WREQ) dma_writes++;
        if (!CPU_CE) ce_run++;
        else if (ce_run > 0) begin
            last_stall = ce_run;
            ce_run     = 0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic w);
        CPU_ADDR = a;
        CPU_DOUT = d;
        CPU_WREQ = w;
    endtask

    // Issue a trigger write so that the halt cycle sees the requested parity.
    task automatic trigger(input logic [7:0] page, input bit want_par);
        step();
        if (ALIGN_ON) begin
            while (((m_cycles + 1) % 2) != int'(want_par)) step();
        end
        drive(16'h4014, page, 1'b1);
        step();
        drive(16'h0000, 8'h00, 1'b0);
    endtask

    task automatic wait_idle(input bit rnd);
        bit          ok;
        logic [15:0] a;
        ok = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge CLK);
            if (CPU_CE) begin
                ok = 1'b1;
                break;
            end
            step();
            if (rnd) begin
                a = 16'($urandom);
                if (a == 16'h4014) a = 16'h4015;
                if (m_busy && m_t >= 10 && m_t <= 400 && $urandom_range(0, 7) == 0) a = 16'h4014;
                drive(a, 8'($urandom), 1'($urandom));
            end
        end
        check("wait_idle_done", ok, 1);
        step();
        drive(16'h0000, 8'h00, 1'b0);
    endtask

    task automatic run_xfer(input logic [7:0] page, input bit want_par, input bit rnd);
        int w0;
        int exp_stall;
        w0 = dma_writes;
        exp_stall = (ALIGN_ON && want_par) ? 514 : 513;
        trigger(page, want_par);
        wait_idle(rnd);
        check("stall_cycles", last_stall, exp_stall);
        check("write_count",  dma_writes - w0, 256);
        check("first_read",   first_read, {page, 8'h00});
        check("last_read",    last_read,  {page, 8'hFF});
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int w0;
        int w1;
        bit hit;
        for (int i = 0; i < 65536; i++) ram[i] = 8'($urandom);

        // Reset: pass-through, CPU ready, not busy.
        #3;
        check("rst_cpu_ce",   CPU_CE,   1);
        check("rst_busy",     BUSY,     0);
        check("rst_bus_addr", BUS_ADDR, 16'h1234);
        check("rst_bus_dout", BUS_DOUT, 8'hA5);
        repeat (3) step();
        RST_N = 1'b1;
        drive(16'h0000, 8'h00, 1'b0);
        repeat (2) step();

        // Idle traffic mirrors the CPU with zero latency.
        drive(16'h0300, 8'h55, 1'b1);
        @(negedge CLK);
        check("idle_wr_addr", BUS_ADDR, 16'h0300);
        check("idle_wr_data", BUS_DOUT, 8'h55);
        check("idle_wr_wreq", BUS_WREQ, 1);
        check("idle_wr_ce",   CPU_CE,   1);
        step();
        drive(16'h2002, 8'h00, 1'b0);
        @(negedge CLK);
        check("idle_rd_addr", BUS_ADDR, 16'h2002);
        check("idle_rd_wreq", BUS_WREQ, 0);
        step();
        drive(16'h0000, 8'h00, 1'b0);

        // Page 02 at even and odd parity.
        run_xfer(8'h02, 1'b0, 1'b0);
        run_xfer(8'h02, 1'b1, 1'b0);

        // Page FF: no carry out of the page, counter wraps to zero.
        run_xfer(8'hFF, 1'b0, 1'b0);
        check("pageff_last_read", last_read, 16'hFFFF);
        check("pageff_cnt_wrap",  dut.cnt,   8'h00);

        // Trigger writes during the transfer are ignored.
        run_xfer(8'h10, 1'b0, 1'b1);

        // Reset after the 100th write aborts the transfer.
        trigger(8'h05, 1'b0);
        w0  = dma_writes;
        hit = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge CLK);
            #1;
            if (dma_writes - w0 == 100) begin
                hit = 1'b1;
                break;
            end
        end
        check("abort_reached_100", hit, 1);
        step();
        RST_N = 1'b0;
        #1;
        check("abort_cpu_ce", CPU_CE, 1);
        check("abort_busy",   BUSY,   0);
        repeat (2) step();
        RST_N = 1'b1;
        w1 = dma_writes;
        repeat (20) step();
        check("abort_no_writes", dma_writes - w1, 0);
        run_xfer(8'h06, 1'b1, 1'b0);

        // Randomised transfers with random CPU traffic around them.
        for (int k = 0; k < 3; k++) begin
            repeat ($urandom_range(1, 10)) begin
                step();
                drive(16'($urandom_range(0, 16'h3FFF)), 8'($urandom), 1'($urandom));
            end
            step();
            drive(16'h0000, 8'h00, 1'b0);
            run_xfer(8'($urandom), 1'($urandom), 1'b1);
        end

        repeat (4) step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
